// File: rtl/shifter_right_seq.sv
// rtl/shifter_right_seq.sv - multi-cycle SRL/SRA right shifter, one barrel stage per clock; SRA gated by `SHIFTER_SRA_EN
module shifter_right_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [5:0]  Signal,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] wrk_q, wrk_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] out_q, out_d;

  logic        op_sra;
  logic        op_ok;
  logic        fill;
  logic [31:0] stage_val;
  logic        unused_dataB_hi;

  // Only the low five bits of the shift amount are meaningful.
  assign unused_dataB_hi = ^dataB[31:5];

`ifdef SHIFTER_SRA_EN
  assign op_sra = (op_q == FN_SRA);
`else
  assign op_sra = 1'b0;
`endif

  assign op_ok = (op_q == FN_SRL) || op_sra;

  // An arithmetic shift never changes the MSB, so the working register's
  // top bit is always the latched dataA[31] and serves as the sign fill.
  assign fill = op_sra & wrk_q[31];

  // Barrel stage for the current k: shift by 2^k when shamt[k] is set.
  always_comb begin
    stage_val = wrk_q;
    case (k_q)
      3'd0: if (shamt_q[0]) stage_val = {{1{fill}},  wrk_q[31:1]};
      3'd1: if (shamt_q[1]) stage_val = {{2{fill}},  wrk_q[31:2]};
      3'd2: if (shamt_q[2]) stage_val = {{4{fill}},  wrk_q[31:4]};
      3'd3: if (shamt_q[3]) stage_val = {{8{fill}},  wrk_q[31:8]};
      3'd4: if (shamt_q[4]) stage_val = {{16{fill}}, wrk_q[31:16]};
      default: stage_val = wrk_q;
    endcase
  end

  // Next-state and datapath update for the IDLE -> SHIFT x5 -> DONE sequence.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wrk_d   = wrk_q;
    shamt_d = shamt_q;
    op_d    = op_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          wrk_d   = dataA;
          shamt_d = dataB[4:0];
          op_d    = Signal;
          out_d   = 32'b0;
          k_d     = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        wrk_d = stage_val;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd4) begin
          out_d   = op_ok ? stage_val : 32'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 3'd0;
      wrk_q   <= 32'b0;
      shamt_q <= 5'b0;
      op_q    <= 6'b0;
      out_q   <= 32'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wrk_q   <= wrk_d;
      shamt_q <= shamt_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  assign dataOut = out_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_shifter_right_seq.sv
// tb/tb_shifter_right_seq.sv - self-checking bench for shifter_right_seq (honours `SHIFTER_SRA_EN)
module tb_shifter_right_seq;

  localparam logic [5:0] SRL = 6'b000010;
  localparam logic [5:0] SRA = 6'b000011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  shifter_right_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .dataOut(dataOut),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] sig);
    int sh;
    sh = int'(b % 32);
    if (sig == SRL) return a >> sh;
`ifdef SHIFTER_SRA_EN
    if (sig == SRA) return $unsigned($signed(a) >>> sh);
`endif
    return 32'b0;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Issue one start pulse and wait for done; then step once back to IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] sig,
                        output logic [31:0] res, output int lat, output int busy_cnt,
                        output logic post_busy, output logic post_done);
    dataA  = a;
    dataB  = b;
    Signal = sig;
    start  = 1'b1;
    step;
    start    = 1'b0;
    lat      = 1;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      step;
      lat++;
      if (busy) busy_cnt++;
    end
    if (!done) lat = 99;
    res = dataOut;
    step;
    post_busy = busy;
    post_done = done;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    dataA = 32'hDEAD_BEEF;
    dataB = 32'd5;
    Signal = SRL;
    repeat (3) step;
    checks++;
    if (dataOut !== 32'b0) begin errors++; $display("FAIL reset_dataOut got=%h exp=%h", dataOut, 32'b0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b0;
    step;
  endtask

  task automatic test_srl_basic;
    logic [31:0] r; int lat; int bc; logic pb; logic pd;
    run_op(32'hF000_0000, 32'd4, SRL, r, lat, bc, pb, pd);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL srl_basic_latency got=%0d exp=6", lat); end
    checks++;
    if (r !== 32'h0F00_0000) begin errors++; $display("FAIL srl_basic_result got=%h exp=0f000000", r); end
    checks++;
    if (bc !== 6) begin errors++; $display("FAIL srl_basic_busy_cycles got=%0d exp=6", bc); end
    checks++;
    if (pb !== 1'b0 || pd !== 1'b0) begin
      errors++; $display("FAIL srl_basic_return_idle got busy=%b done=%b exp busy=0 done=0", pb, pd);
    end
  endtask

  task automatic test_boundary;
    logic [31:0] amt [3];
    logic [31:0] expv [3];
    logic [31:0] r; int lat; int bc; logic pb; logic pd;
    amt[0] = 32'd0;          expv[0] = 32'h8000_0001;
    amt[1] = 32'd31;         expv[1] = 32'h0000_0001;
    amt[2] = 32'hFFFF_FFE3;  expv[2] = 32'h1000_0000;
    for (int i = 0; i < 3; i++) begin
      run_op(32'h8000_0001, amt[i], SRL, r, lat, bc, pb, pd);
      checks++;
      if (r !== expv[i]) begin errors++; $display("FAIL boundary_%0d got=%h exp=%h", i, r, expv[i]); end
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL boundary_latency_%0d got=%0d exp=6", i, lat); end
    end
  endtask

  task automatic test_sra;
    logic [31:0] r; int lat; int bc; logic pb; logic pd;
    logic [31:0] expv;
`ifdef SHIFTER_SRA_EN
    expv = 32'hFFFF_FFFF;
`else
    expv = 32'h0000_0000;
`endif
    run_op(32'h8000_0000, 32'd31, SRA, r, lat, bc, pb, pd);
    checks++;
    if (r !== expv) begin errors++; $display("FAIL sra_result got=%h exp=%h", r, expv); end
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL sra_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_unsupported;
    logic [31:0] r; int lat; int bc; logic pb; logic pd;
    run_op(32'h1234_5678, 32'd1, 6'b000000, r, lat, bc, pb, pd);
    checks++;
    if (r !== 32'b0) begin errors++; $display("FAIL unsupported_result got=%h exp=0", r); end
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL unsupported_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_random;
    logic [31:0] a; logic [31:0] b; logic [5:0] s;
    logic [31:0] r; int lat; int bc; logic pb; logic pd;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0, 1: s = SRL;
        2: s = SRA;
        default: s = 6'($urandom);
      endcase
      run_op(a, b, s, r, lat, bc, pb, pd);
      checks++;
      if (r !== ref_shift(a, b, s) || lat !== 6) begin
        errors++;
        $display("FAIL random_%0d a=%h b=%h op=%b got=%h lat=%0d exp=%h lat=6",
                 i, a, b, s, r, lat, ref_shift(a, b, s));
      end
    end
  endtask

  task automatic test_back_to_back;
    int first_done; int ndone; int last; int bad_gap; int bad_val;
    logic [31:0] a; logic [31:0] b;
    a = $urandom;
    b = $urandom;
    dataA = a; dataB = b; Signal = SRL;
    start = 1'b1;
    first_done = -1; ndone = 0; last = 0; bad_gap = 0; bad_val = 0;
    for (int s = 1; s <= 28; s++) begin
      step;
      if (done) begin
        if (first_done < 0) first_done = s;
        else if (s - last != 7) bad_gap++;
        if (dataOut !== ref_shift(a, b, SRL)) bad_val++;
        last = s;
        ndone++;
      end
    end
    start = 1'b0;
    step;
    checks++;
    if (first_done !== 6) begin errors++; $display("FAIL held_start_first_done got=%0d exp=6", first_done); end
    checks++;
    if (ndone !== 4 || bad_gap !== 0) begin
      errors++; $display("FAIL held_start_rate got dones=%0d bad_gaps=%0d exp dones=4 bad_gaps=0", ndone, bad_gap);
    end
    checks++;
    if (bad_val !== 0) begin errors++; $display("FAIL held_start_values got bad=%0d exp=0", bad_val); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL held_start_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_change_mid;
    logic [31:0] a; logic [31:0] b; int n;
    a = $urandom;
    b = $urandom;
    dataA = a; dataB = b; Signal = SRL;
    start = 1'b1;
    step;
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      dataA = $urandom; dataB = $urandom; Signal = 6'($urandom);
      step;
      n++;
    end
    checks++;
    if (!done || dataOut !== ref_shift(a, b, SRL)) begin
      errors++; $display("FAIL change_mid got=%h done=%b exp=%h done=1", dataOut, done, ref_shift(a, b, SRL));
    end
    step;
  endtask

  task automatic test_start_while_busy;
    logic [31:0] a; logic [31:0] b; int n;
    a = $urandom;
    b = $urandom;
    dataA = a; dataB = b; Signal = SRL;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    dataA = ~a; dataB = b + 32'd7; Signal = SRL;
    start = 1'b1;
    step;
    start = 1'b0;
    n = 3;
    while (!done && n < 20) begin step; n++; end
    checks++;
    if (!done || n !== 6 || dataOut !== ref_shift(a, b, SRL)) begin
      errors++; $display("FAIL busy_start_ignored got=%h n=%0d exp=%h n=6", dataOut, n, ref_shift(a, b, SRL));
    end
    start = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_during_done got busy=%b exp=0", busy); end
    step;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL no_queueing got busy=%b done=%b exp busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    logic [31:0] r; int lat; int bc; logic pb; logic pd;
    dataA = 32'hCAFE_F00D; dataB = 32'd9; Signal = SRL;
    start = 1'b1;
    step;
    start = 1'b0;
    step;
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || dataOut !== 32'b0) begin
      errors++; $display("FAIL reset_mid got busy=%b done=%b dataOut=%h exp 0 0 0", busy, done, dataOut);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin errors++; $display("FAIL reset_mid_no_done got=%0d exp=0", ndone); end
    run_op(32'hCAFE_F00D, 32'd9, SRL, r, lat, bc, pb, pd);
    checks++;
    if (r !== 32'hCAFE_F00D >> 9 || lat !== 6) begin
      errors++; $display("FAIL reset_mid_restart got=%h lat=%0d exp=%h lat=6", r, lat, 32'hCAFE_F00D >> 9);
    end
  endtask

  initial begin
    test_reset;
    test_srl_basic;
    test_boundary;
    test_sra;
    test_unsupported;
    test_random;
    test_back_to_back;
    test_change_mid;
    test_start_while_busy;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shifter_right_seq.md
# shifter_right_seq

Multi-cycle logical/arithmetic right shifter for the ALU, the right-direction counterpart of the combinational SLL barrel shifter. It accepts one operand and a shift amount on a start pulse and applies one binary-weighted barrel stage per clock: 1, 2, 4, 8, then 16. It returns the result with a one-cycle done pulse. The ALU top uses it for SRL/SRA function codes, sharing the same dataA/dataB/Signal conventions as the other ALU sub-units.

## Interface
- SRL, 6'b000010, function code for logical right shift.
- SRA, 6'b000011, function code for arithmetic right shift (only honoured with SHIFTER_SRA_EN).
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- dataA  input  32  operand to shift.
- dataB  input  32  shift amount; only dataB[4:0] used, [31:5] ignored.
- Signal  input  6  function code.
- dataOut  output  32  registered result; held until next accepted start or reset.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse; dataOut valid in this cycle.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 latches dataA into the working register, dataB[4:0] into shamt, and Signal into op.
  - Clears dataOut to 0.
  - Loads stage counter k=0 and enters SHIFT.
- Unsupported op: any Signal other than SRL (or SRA when enabled) still runs the full sequence, and dataOut is forced to 32'b0 at DONE.
- SHIFT, on each edge:
  - If shamt[k]=1, the working register shifts right by 2^k.
  - Vacated MSBs are filled with 0 for SRL, or with the latched dataA[31] for SRA.
  - If shamt[k]=0, the working register holds.
  - k increments. After the edge that applies k=4, the FSM goes to DONE.
- DONE:
  - dataOut <= working register (or 0 for unsupported op) on the edge entering DONE.
  - done=1 for exactly one cycle, then the FSM returns to IDLE.
- Shift amount 0 still takes the full sequence; result = dataA.
- Shift amount 31 SRL yields dataA[31] in bit 0 with all other bits 0.
- start while busy is ignored: no latch, no restart, no queueing.
- start in the same cycle that done=1 is ignored, since the FSM is still in DONE. The earliest accepted restart is the following cycle (IDLE).
- Operand inputs may change after the start cycle without effect.

## Timing
- Reset values:
  - state=IDLE, k=0.
  - dataOut=32'b0, busy=0, done=0.
  - Working register and shamt are cleared to 0.
- Reset mid-operation: the next edge returns to IDLE with all outputs at their reset values. No done pulse is produced for the aborted operation.
- Latency:
  - start sampled at edge E0.
  - Stages are applied at E1..E5.
  - dataOut updates and done=1 in the cycle after E5; busy drops after E6.
- Throughput: one operation per 7 cycles with back-to-back starts (start accepted at E0 and E7).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SHIFTER_SRA_EN:
  - Defined: Signal=6'b000011 performs an arithmetic shift with sign fill from the latched dataA[31].
  - Undefined: 6'b000011 is treated as an unsupported op (result 0, timing unchanged). SRL behaviour is identical in both builds.

## Test plan
- SRL basic: dataA=32'hF000_0000, dataB=4, Signal=SRL, start pulse -> done exactly 6 cycles after the start cycle; dataOut=32'h0F00_0000; busy high for 6 cycles.
- Boundary amounts:
  - dataA=32'h8000_0001 with dataB=0 -> 32'h8000_0001.
  - Same dataA with dataB=31 -> 32'h0000_0001.
  - Same dataA with dataB=32'hFFFF_FFE3 (only low 5 bits = 3 used) -> 32'h1000_0000.
- SRA (SHIFTER_SRA_EN defined): dataA=32'h8000_0000, dataB=31 -> 32'hFFFF_FFFF. Without the macro, same stimulus -> 32'h0000_0000.
- Unsupported op: Signal=6'b000000, dataA=32'h1234_5678, dataB=1 -> done after 6 cycles, dataOut=0.
- Handshake:
  - start held high continuously -> operations accepted every 7 cycles only.
  - Changing dataA mid-SHIFT does not alter the result.
  - A second start while busy is ignored.
- Reset mid-op: assert reset during SHIFT (k=2) -> next cycle busy=0, done=0, dataOut=0. No done pulse for the aborted operation; a new start then completes normally.
